fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 92 +++++++++
 tb/tb_fetch_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - two-state instruction fetch unit; FETCH_ALIGN_CHECK_EN enables the misaligned-redirect trap
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirectTarget,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemValid,
  input  logic [31:0] imemData,
  output logic [31:0] pcQ,
  output logic [31:0] pcD,
  output logic [31:0] instruction,
  output logic        instrValid,
  output logic        misalignErr
);

  typedef enum logic {FETCH, PRESENT} stateType;

  stateType state;
  stateType nextState;
  logic     takeResp;
  logic     consume;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    takeResp  = 1'b0;
    consume   = 1'b0;
    imemReq   = 1'b0;
    if (state == FETCH && !reset) imemReq = 1'b1;
    // Redirect outranks both a memory response and a stall.
    if (redirect) begin
      nextState = FETCH;
    end else begin
      case (state)
        FETCH: if (imemValid) begin
          takeResp  = 1'b1;
          nextState = PRESENT;
        end
        PRESENT: if (!stall) begin
          consume   = 1'b1;
          nextState = FETCH;
        end
        default: nextState = FETCH;
      endcase
    end
  end

  assign imemAddr = pcD;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pcD         <= RESET_PC;
      pcQ         <= RESET_PC;
      instruction <= 32'h0;
      instrValid  <= 1'b0;
    end else if (redirect) begin
      instrValid <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      // A misaligned target is refused; the current pcD is refetched.
      if (redirectTarget[1:0] == 2'b00) pcD <= redirectTarget;
`else
      pcD <= redirectTarget & 32'hFFFF_FFFC;
`endif
    end else if (takeResp) begin
      instruction <= imemData;
      pcQ         <= pcD;
      pcD         <= pcD + 32'd4;
      instrValid  <= 1'b1;
    end else if (consume) begin
      instrValid <= 1'b0;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) misalignErr <= 1'b0;
    else if (redirect && redirectTarget[1:0] != 2'b00) misalignErr <= 1'b1;
  end
`else
  assign misalignErr = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed bench for fetch_unit with an abstract reference model
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h00000000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirectTarget = 32'h0;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemValid = 1'b0;
  logic [31:0] imemData = 32'h0;
  logic [31:0] pcQ;
  logic [31:0] pcD;
  logic [31:0] instruction;
  logic        instrValid;
  logic        misalignErr;

  int vectors = 0;
  int miscompares = 0;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clock(clock), .reset(reset), .stall(stall), .redirect(redirect),
    .redirectTarget(redirectTarget), .imemReq(imemReq), .imemAddr(imemAddr),
    .imemValid(imemValid), .imemData(imemData), .pcQ(pcQ), .pcD(pcD),
    .instruction(instruction), .instrValid(instrValid), .misalignErr(misalignErr)
  );

  always #5 clock = ~clock;

  // Model: "holding an instruction" is the only state; fetching means nothing is held.
  logic [31:0] mPcD = RST_PC;
  logic [31:0] mPcQ = RST_PC;
  logic [31:0] mInstr = 32'h0;
  logic        mHeld = 1'b0;
  logic        mErr = 1'b0;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'h1234};
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mPcD = RST_PC; mPcQ = RST_PC; mInstr = 32'h0; mHeld = 1'b0; mErr = 1'b0;
    end else if (redirect) begin
      mHeld = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      if (redirectTarget % 4 != 0) mErr = 1'b1;
      else mPcD = redirectTarget;
`else
      mPcD = redirectTarget - (redirectTarget % 4);
`endif
    end else if (!mHeld) begin
      if (imemValid) begin
        mInstr = imemData; mPcQ = mPcD; mPcD = mPcD + 32'd4; mHeld = 1'b1;
      end
    end else if (!stall) begin
      mHeld = 1'b0;
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    cmp("imemReq", {31'b0, imemReq}, {31'b0, !reset && !mHeld});
    if (!reset && !mHeld) cmp("imemAddr", imemAddr, mPcD);
    cmp("pcD", pcD, mPcD);
    cmp("instrValid", {31'b0, instrValid}, {31'b0, mHeld});
    if (mHeld) begin
      cmp("pcQ", pcQ, mPcQ);
      cmp("instruction", instruction, mInstr);
    end
    cmp("misalignErr", {31'b0, misalignErr}, {31'b0, mErr});
  end

  task automatic step(input logic st, input logic rd, input logic [31:0] tgt, input logic vld);
    stall = st; redirect = rd; redirectTarget = tgt; imemValid = vld;
    imemData = memWord(mPcD);
    @(negedge clock); #2;
  endtask

  initial begin
    #1 reset = 1'b1;
    @(negedge clock); #2;
    cmp("rst_req", {31'b0, imemReq}, 32'h0);
    cmp("rst_pcQ", pcQ, 32'h0);
    cmp("rst_instr", instruction, 32'h0);
    cmp("rst_valid", {31'b0, instrValid}, 32'h0);
    @(negedge clock); #2;
    reset = 1'b0;
    #1;
    cmp("first_req", {31'b0, imemReq}, 32'h1);
    cmp("first_addr", imemAddr, 32'h0);

    // 1-cycle memory, no stall
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1);
      cmp("seq_pcQ", pcQ, 32'(i * 4));
      cmp("seq_instr", instruction, memWord(32'(i * 4)));
      cmp("seq_valid", {31'b0, instrValid}, 32'h1);
      step(0, 0, 0, 0);
      cmp("seq_addr", imemAddr, 32'(i * 4 + 4));
    end

    // response delayed three cycles
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0);
      cmp("wait_req", {31'b0, imemReq}, 32'h1);
      cmp("wait_addr", imemAddr, 32'hC);
    end
    step(0, 0, 0, 1);
    cmp("late_valid", {31'b0, instrValid}, 32'h1);
    cmp("late_pcQ", pcQ, 32'hC);

    // five stalled cycles; a stray imemValid must not disturb the held word
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, i[0]);
      cmp("stall_pcQ", pcQ, 32'hC);
      cmp("stall_req", {31'b0, imemReq}, 32'h0);
    end
    step(0, 0, 0, 0);
    cmp("resume_addr", imemAddr, 32'h10);

    // redirect coincident with a response
    step(0, 1, 32'h40, 1);
    cmp("redir_valid", {31'b0, instrValid}, 32'h0);
    cmp("redir_addr", imemAddr, 32'h40);
    step(0, 0, 0, 1);
    cmp("redir_pcQ", pcQ, 32'h40);
    step(0, 0, 0, 0);

    // wrap at the top of the address space
    step(0, 1, 32'hFFFFFFFC, 0);
    step(0, 0, 0, 1);
    cmp("wrap_pcQ", pcQ, 32'hFFFFFFFC);
    step(0, 0, 0, 0);
    cmp("wrap_addr", imemAddr, 32'h0);

    // redirect while stalled drops the presented instruction
    step(0, 0, 0, 1);
    step(1, 1, 32'h100, 0);
    cmp("drop_valid", {31'b0, instrValid}, 32'h0);
    cmp("drop_addr", imemAddr, 32'h100);

    // misaligned redirect
    step(0, 1, 32'h42, 0);
`ifdef FETCH_ALIGN_CHECK_EN
    cmp("mis_addr", imemAddr, 32'h100);
    cmp("mis_err", {31'b0, misalignErr}, 32'h1);
`else
    cmp("mis_addr", imemAddr, 32'h40);
    cmp("mis_err", {31'b0, misalignErr}, 32'h0);
`endif

    // reset in the middle of an outstanding request
    step(0, 0, 0, 0);
    reset = 1'b1;
    #1;
    cmp("abort_req", {31'b0, imemReq}, 32'h0);
    cmp("abort_pcD", pcD, 32'h0);
    imemValid = 1'b1;
    @(negedge clock); #2;
    imemValid = 1'b0;
    reset = 1'b0;
    #1;
    cmp("abort_valid", {31'b0, instrValid}, 32'h0);
    cmp("abort_addr", imemAddr, 32'h0);
    step(0, 0, 0, 1);
    cmp("after_pcQ", pcQ, 32'h0);
    step(0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
